// File: rtl/pcs_pkg.sv
// Shared PCS/GMII transmit definitions: xmit encodings, GMII framing bytes and scheduler states.
package pcs_pkg;

  localparam logic [2:0] XMIT_IDLE          = 3'd0;
  localparam logic [2:0] XMIT_CONFIGURATION = 3'd1;
  localparam logic [2:0] XMIT_DATA          = 3'd2;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_DATA,
    S_DRAIN,
    S_IPG
  } state_e;

endpackage

// File: rtl/ipg_counter.sv
// Loadable down-counter that saturates at zero; done is high while the count is zero.
module ipg_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/tx_frame_sched.sv
// GMII-side transmit frame scheduler: preamble/SFD insertion, payload streaming, abort handling
// and inter-packet gap enforcement ahead of the 1000BASE-X PCS transmit block.
module tx_frame_sched
  import pcs_pkg::*;
#(
  parameter int unsigned PREAMBLE_BYTES = 7,
  parameter int unsigned IPG_BYTES      = 12,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             GTX_CLK,
  input  logic             mr_main_reset,
  input  logic [2:0]       xmit,
  input  logic             COL,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  input  logic             s_err,
  output logic             s_ready,
  output logic             TX_EN,
  output logic             TX_ER,
  output logic [7:0]       TXD,
  output logic             busy,
  output logic             col_abort,
  output logic             underrun,
  output logic [CNT_W-1:0] frames_sent
);

  localparam int unsigned MaxLoad = (IPG_BYTES > PREAMBLE_BYTES) ? IPG_BYTES : PREAMBLE_BYTES;
  localparam int unsigned CntW    = $clog2(MaxLoad + 1);
  localparam logic [CntW-1:0] PreLoad = CntW'(PREAMBLE_BYTES - 1);
  localparam logic [CntW-1:0] IpgLoad = CntW'(IPG_BYTES - 1);

  state_e           state_q, state_d;
  logic             tx_en_q, tx_en_d;
  logic             tx_er_q, tx_er_d;
  logic [7:0]       txd_q, txd_d;
  logic             col_abort_q, col_abort_d;
  logic             underrun_q, underrun_d;
  logic             err_seen_q, err_seen_d;
  logic [CNT_W-1:0] frames_sent_q, frames_sent_d;

  logic            cnt_load, cnt_en, cnt_done;
  logic [CntW-1:0] cnt_val;

  // One counter serves both the preamble and the gap; the two phases never overlap.
  ipg_counter #(
    .Width(CntW)
  ) u_ipg_counter (
    .clk_i     (GTX_CLK),
    .rst_i     (mr_main_reset),
    .load_i    (cnt_load),
    .load_val_i(cnt_val),
    .en_i      (cnt_en),
    .done_o    (cnt_done)
  );

  assign cnt_en  = (state_q == S_PRE) || (state_q == S_IPG);
  assign s_ready = (state_q == S_SFD) || (state_q == S_DATA) || (state_q == S_DRAIN);
  assign busy    = (state_q != S_IDLE);

  always_comb begin
    state_d       = state_q;
    tx_en_d       = 1'b0;
    tx_er_d       = 1'b0;
    txd_d         = 8'h00;
    col_abort_d   = 1'b0;
    underrun_d    = 1'b0;
    err_seen_d    = err_seen_q;
    frames_sent_d = frames_sent_q;
    cnt_load      = 1'b0;
    cnt_val       = IpgLoad;

    unique case (state_q)
      S_IDLE: begin
        if (s_valid && (xmit == XMIT_DATA) && cnt_done) begin
          state_d    = S_PRE;
          tx_en_d    = 1'b1;
          txd_d      = PREAMBLE_BYTE;
          err_seen_d = 1'b0;
          cnt_load   = 1'b1;
          cnt_val    = PreLoad;
        end
      end
      S_PRE: begin
        if (COL) begin
          col_abort_d = 1'b1;
          state_d     = S_DRAIN;
        end else if (xmit != XMIT_DATA) begin
          state_d = S_DRAIN;
        end else begin
          tx_en_d = 1'b1;
          if (cnt_done) begin
            txd_d   = SFD_BYTE;
            state_d = S_SFD;
          end else begin
            txd_d = PREAMBLE_BYTE;
          end
        end
      end
      // The SFD cycle already accepts the first payload byte, so it shares the data handling.
      S_SFD, S_DATA: begin
        if (COL || (xmit != XMIT_DATA)) begin
          col_abort_d = COL;
          if (s_valid && s_last) begin
            state_d  = S_IPG;
            cnt_load = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (!s_valid) begin
          tx_en_d    = 1'b1;
          tx_er_d    = 1'b1;
          underrun_d = 1'b1;
          state_d    = S_DRAIN;
        end else begin
          tx_en_d    = 1'b1;
          tx_er_d    = s_err;
          txd_d      = s_data;
          err_seen_d = err_seen_q | s_err;
          state_d    = S_DATA;
          if (s_last) begin
            state_d  = S_IPG;
            cnt_load = 1'b1;
            if (!(err_seen_q || s_err)) begin
              frames_sent_d = frames_sent_q + CNT_W'(1);
            end
          end
        end
      end
      S_DRAIN: begin
        if (s_valid && s_last) begin
          state_d  = S_IPG;
          cnt_load = 1'b1;
        end
      end
      S_IPG: begin
        if (cnt_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
    if (mr_main_reset) begin
      state_q       <= S_IDLE;
      tx_en_q       <= 1'b0;
      tx_er_q       <= 1'b0;
      txd_q         <= 8'h00;
      col_abort_q   <= 1'b0;
      underrun_q    <= 1'b0;
      err_seen_q    <= 1'b0;
      frames_sent_q <= '0;
    end else begin
      state_q       <= state_d;
      tx_en_q       <= tx_en_d;
      tx_er_q       <= tx_er_d;
      txd_q         <= txd_d;
      col_abort_q   <= col_abort_d;
      underrun_q    <= underrun_d;
      err_seen_q    <= err_seen_d;
      frames_sent_q <= frames_sent_d;
    end
  end

  assign TX_EN       = tx_en_q;
  assign TX_ER       = tx_er_q;
  assign TXD         = txd_q;
  assign col_abort   = col_abort_q;
  assign underrun    = underrun_q;
  assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_tx_frame_sched.sv
// Directed per-cycle vector bench for tx_frame_sched (PREAMBLE_BYTES=7, IPG_BYTES=12).
module tb_tx_frame_sched;

  localparam logic [2:0] XD = 3'd2;
  localparam logic [2:0] XC = 3'd1;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  xmit = XD;
  logic        col = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_last = 1'b0;
  logic        s_err = 1'b0;
  logic        s_ready, tx_en, tx_er, busy, col_abort, underrun;
  logic [7:0]  txd;
  logic [15:0] frames_sent;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tx_frame_sched #(
    .PREAMBLE_BYTES(7),
    .IPG_BYTES     (12),
    .CNT_W         (16)
  ) dut (
    .GTX_CLK      (clk),
    .mr_main_reset(rst),
    .xmit         (xmit),
    .COL          (col),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_last       (s_last),
    .s_err        (s_err),
    .s_ready      (s_ready),
    .TX_EN        (tx_en),
    .TX_ER        (tx_er),
    .TXD          (txd),
    .busy         (busy),
    .col_abort    (col_abort),
    .underrun     (underrun),
    .frames_sent  (frames_sent)
  );

  typedef struct {
    logic        vld;
    logic [7:0]  dat;
    logic        lst;
    logic        err;
    logic        col;
    logic [2:0]  xm;
    logic        en;
    logic        er;
    logic [7:0]  txd;
    logic        rdy;
    logic        bsy;
    logic        cab;
    logic        und;
    logic [15:0] fs;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input int n, input logic vld, input logic [7:0] dat, input logic lst,
                   input logic err, input logic c, input logic [2:0] xm, input logic en,
                   input logic er, input logic [7:0] d, input logic rdy, input logic bsy,
                   input logic cab, input logic und, input logic [15:0] fs);
    vec_t e;
    e.vld = vld; e.dat = dat; e.lst = lst; e.err = err; e.col = c; e.xm = xm;
    e.en = en; e.er = er; e.txd = d; e.rdy = rdy; e.bsy = bsy; e.cab = cab; e.und = und;
    e.fs = fs;
    for (int i = 0; i < n; i++) tbl.push_back(e);
  endtask

  task automatic chk(input string tag, input int idx, input string field,
                     input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] %s: got %0h expected %0h", tag, idx, field, act, exp);
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_tbl(input string tag);
    foreach (tbl[i]) begin
      s_valid = tbl[i].vld; s_data = tbl[i].dat; s_last = tbl[i].lst;
      s_err = tbl[i].err; col = tbl[i].col; xmit = tbl[i].xm;
      @(negedge clk);
      chk(tag, i, "TX_EN", 16'(tx_en), 16'(tbl[i].en));
      chk(tag, i, "TX_ER", 16'(tx_er), 16'(tbl[i].er));
      chk(tag, i, "TXD", 16'(txd), 16'(tbl[i].txd));
      chk(tag, i, "s_ready", 16'(s_ready), 16'(tbl[i].rdy));
      chk(tag, i, "busy", 16'(busy), 16'(tbl[i].bsy));
      chk(tag, i, "col_abort", 16'(col_abort), 16'(tbl[i].cab));
      chk(tag, i, "underrun", 16'(underrun), 16'(tbl[i].und));
      chk(tag, i, "frames_sent", frames_sent, tbl[i].fs);
      @(posedge clk);
      #1;
    end
    tbl.delete();
  endtask

  // Reset is asserted between clock edges so the checks prove it acts asynchronously.
  task automatic reset_chk(input string tag);
    rst = 1'b1;
    s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; s_err = 1'b0; col = 1'b0; xmit = XD;
    #1;
    chk(tag, 0, "TX_EN", 16'(tx_en), 16'd0);
    chk(tag, 0, "TX_ER", 16'(tx_er), 16'd0);
    chk(tag, 0, "TXD", 16'(txd), 16'd0);
    chk(tag, 0, "s_ready", 16'(s_ready), 16'd0);
    chk(tag, 0, "busy", 16'(busy), 16'd0);
    chk(tag, 0, "col_abort", 16'(col_abort), 16'd0);
    chk(tag, 0, "underrun", 16'(underrun), 16'd0);
    chk(tag, 0, "frames_sent", frames_sent, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    reset_chk("reset0");

    // 4-byte frame: 7x55, D5, 11..44, TX_EN high 12 cycles, then 12-cycle gap.
    v(1,  H, 8'h11, L, L, L, XD,  L, L, 8'h00, L, L, L, L, 16'd0);
    v(7,  H, 8'h11, L, L, L, XD,  H, L, 8'h55, L, H, L, L, 16'd0);
    v(1,  H, 8'h11, L, L, L, XD,  H, L, 8'hD5, H, H, L, L, 16'd0);
    v(1,  H, 8'h22, L, L, L, XD,  H, L, 8'h11, H, H, L, L, 16'd0);
    v(1,  H, 8'h33, L, L, L, XD,  H, L, 8'h22, H, H, L, L, 16'd0);
    v(1,  H, 8'h44, H, L, L, XD,  H, L, 8'h33, H, H, L, L, 16'd0);
    v(1,  L, 8'h00, L, L, L, XD,  H, L, 8'h44, L, H, L, L, 16'd1);
    v(11, L, 8'h00, L, L, L, XD,  L, L, 8'h00, L, H, L, L, 16'd1);
    v(1,  L, 8'h00, L, L, L, XD,  L, L, 8'h00, L, L, L, L, 16'd1);
    run_tbl("frame4");

    // Collision on the 3rd payload byte, last byte drained.
    v(1,  H, 8'h01, L, L, L, XD,  L, L, 8'h00, L, L, L, L, 16'd1);
    v(7,  H, 8'h01, L, L, L, XD,  H, L, 8'h55, L, H, L, L, 16'd1);
    v(1,  H, 8'h01, L, L, L, XD,  H, L, 8'hD5, H, H, L, L, 16'd1);
    v(1,  H, 8'h02, L, L, L, XD,  H, L, 8'h01, H, H, L, L, 16'd1);
    v(1,  H, 8'h03, L, L, H, XD,  H, L, 8'h02, H, H, L, L, 16'd1);
    v(1,  H, 8'h04, H, L, L, XD,  L, L, 8'h00, H, H, H, L, 16'd1);
    v(12, L, 8'h00, L, L, L, XD,  L, L, 8'h00, L, H, L, L, 16'd1);
    v(1,  L, 8'h00, L, L, L, XD,  L, L, 8'h00, L, L, L, L, 16'd1);
    run_tbl("collision");

    // Underrun after two bytes: error byte, drain two bytes, gap.
    v(1,  H, 8'h5A, L, L, L, XD,  L, L, 8'h00, L, L, L, L, 16'd1);
    v(7,  H, 8'h5A, L, L, L, XD,  H, L, 8'h55, L, H, L, L, 16'd1);
    v(1,  H, 8'h5A, L, L, L, XD,  H, L, 8'hD5, H, H, L, L, 16'd1);
    v(1,  H, 8'h5B, L, L, L, XD,  H, L, 8'h5A, H, H, L, L, 16'd1);
    v(1,  L, 8'h00, L, L, L, XD,  H, L, 8'h5B, H, H, L, L, 16'd1);
    v(1,  H, 8'h5C, L, L, L, XD,  H, H, 8'h00, H, H, L, H, 16'd1);
    v(1,  H, 8'h5D, H, L, L, XD,  L, L, 8'h00, H, H, L, L, 16'd1);
    v(12, L, 8'h00, L, L, L, XD,  L, L, 8'h00, L, H, L, L, 16'd1);
    v(1,  L, 8'h00, L, L, L, XD,  L, L, 8'h00, L, L, L, L, 16'd1);
    run_tbl("underrun");

    // CONFIGURATION mode defers the start until xmit returns to DATA.
    v(5,  H, 8'hC1, H, L, L, XC,  L, L, 8'h00, L, L, L, L, 16'd1);
    v(1,  H, 8'hC1, H, L, L, XD,  L, L, 8'h00, L, L, L, L, 16'd1);
    v(7,  H, 8'hC1, H, L, L, XD,  H, L, 8'h55, L, H, L, L, 16'd1);
    v(1,  H, 8'hC1, H, L, L, XD,  H, L, 8'hD5, H, H, L, L, 16'd1);
    v(1,  L, 8'h00, L, L, L, XD,  H, L, 8'hC1, L, H, L, L, 16'd2);
    v(11, L, 8'h00, L, L, L, XD,  L, L, 8'h00, L, H, L, L, 16'd2);
    v(1,  L, 8'h00, L, L, L, XD,  L, L, 8'h00, L, L, L, L, 16'd2);
    run_tbl("xmit_defer");

    reset_chk("reset1");

    // Back-to-back 1-byte frames with s_valid held: exactly 12 idle cycles between them.
    v(1,  H, 8'hA1, H, L, L, XD,  L, L, 8'h00, L, L, L, L, 16'd0);
    v(7,  H, 8'hA1, H, L, L, XD,  H, L, 8'h55, L, H, L, L, 16'd0);
    v(1,  H, 8'hA1, H, L, L, XD,  H, L, 8'hD5, H, H, L, L, 16'd0);
    v(1,  H, 8'hB2, H, L, L, XD,  H, L, 8'hA1, L, H, L, L, 16'd1);
    v(11, H, 8'hB2, H, L, L, XD,  L, L, 8'h00, L, H, L, L, 16'd1);
    v(1,  H, 8'hB2, H, L, L, XD,  L, L, 8'h00, L, L, L, L, 16'd1);
    v(7,  H, 8'hB2, H, L, L, XD,  H, L, 8'h55, L, H, L, L, 16'd1);
    v(1,  H, 8'hB2, H, L, L, XD,  H, L, 8'hD5, H, H, L, L, 16'd1);
    v(1,  L, 8'h00, L, L, L, XD,  H, L, 8'hB2, L, H, L, L, 16'd2);
    v(11, L, 8'h00, L, L, L, XD,  L, L, 8'h00, L, H, L, L, 16'd2);
    v(1,  L, 8'h00, L, L, L, XD,  L, L, 8'h00, L, L, L, L, 16'd2);
    run_tbl("b2b");

    // s_err on the middle byte: TX_ER aligned with it, frame not counted.
    v(1,  H, 8'h71, L, L, L, XD,  L, L, 8'h00, L, L, L, L, 16'd2);
    v(7,  H, 8'h71, L, L, L, XD,  H, L, 8'h55, L, H, L, L, 16'd2);
    v(1,  H, 8'h71, L, L, L, XD,  H, L, 8'hD5, H, H, L, L, 16'd2);
    v(1,  H, 8'h72, L, H, L, XD,  H, L, 8'h71, H, H, L, L, 16'd2);
    v(1,  H, 8'h73, H, L, L, XD,  H, H, 8'h72, H, H, L, L, 16'd2);
    v(1,  L, 8'h00, L, L, L, XD,  H, L, 8'h73, L, H, L, L, 16'd2);
    v(11, L, 8'h00, L, L, L, XD,  L, L, 8'h00, L, H, L, L, 16'd2);
    v(1,  L, 8'h00, L, L, L, XD,  L, L, 8'h00, L, L, L, L, 16'd2);
    run_tbl("s_err");

    // A clean frame after the errored one is counted again.
    v(1,  H, 8'h99, H, L, L, XD,  L, L, 8'h00, L, L, L, L, 16'd2);
    v(7,  H, 8'h99, H, L, L, XD,  H, L, 8'h55, L, H, L, L, 16'd2);
    v(1,  H, 8'h99, H, L, L, XD,  H, L, 8'hD5, H, H, L, L, 16'd2);
    v(1,  L, 8'h00, L, L, L, XD,  H, L, 8'h99, L, H, L, L, 16'd3);
    v(11, L, 8'h00, L, L, L, XD,  L, L, 8'h00, L, H, L, L, 16'd3);
    v(1,  L, 8'h00, L, L, L, XD,  L, L, 8'h00, L, L, L, L, 16'd3);
    run_tbl("clean_after_err");

    // COL together with the accepted last byte: straight to the gap, pulse, no count.
    v(1,  H, 8'hEE, H, L, L, XD,  L, L, 8'h00, L, L, L, L, 16'd3);
    v(7,  H, 8'hEE, H, L, L, XD,  H, L, 8'h55, L, H, L, L, 16'd3);
    v(1,  H, 8'hEE, H, L, H, XD,  H, L, 8'hD5, H, H, L, L, 16'd3);
    v(1,  L, 8'h00, L, L, L, XD,  L, L, 8'h00, L, H, H, L, 16'd3);
    v(11, L, 8'h00, L, L, L, XD,  L, L, 8'h00, L, H, L, L, 16'd3);
    v(1,  L, 8'h00, L, L, L, XD,  L, L, 8'h00, L, L, L, L, 16'd3);
    run_tbl("col_last");

    // Reset in the middle of the preamble drops TX_EN without a clock edge.
    v(1,  H, 8'h42, L, L, L, XD,  L, L, 8'h00, L, L, L, L, 16'd3);
    v(3,  H, 8'h42, L, L, L, XD,  H, L, 8'h55, L, H, L, L, 16'd3);
    run_tbl("pre_midrst");
    reset_chk("midrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
